// File: rtl/animation_sequencer.sv
// Sequences a transaction animation: PROC_STEPS process draws, then optionally TRAVEL_STEPS
// travel draws, handshaking each draw with the screen datapath; supports abort and a watchdog.
module animation_sequencer #(
    parameter int unsigned PROC_STEPS     = 5,
    parameter int unsigned TRAVEL_STEPS   = 5,
    parameter int unsigned STEP_W         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TO_W           = 26
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start_animation,
    input  logic              skip_travel,
    input  logic              done_step,
    input  logic              done_travel,
    input  logic              return_signal,
    output logic              load_screen,
    output logic [STEP_W-1:0] step,
    output logic [STEP_W-1:0] travel,
    output logic              busy,
    output logic              finished_transaction,
    output logic              aborted,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadStep,
        StWaitStep,
        StLoadTravel,
        StWaitTravel,
        StFinish,
        StHold
    } state_t;

    localparam logic [STEP_W-1:0] PROC_LAST   = STEP_W'(PROC_STEPS - 1);
    localparam logic [STEP_W-1:0] TRAVEL_LAST = STEP_W'(TRAVEL_STEPS - 1);
    localparam logic [TO_W-1:0]   WD_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   travel_q, travel_d;
    logic                skip_q, skip_d;
    logic [TO_W-1:0]     wd_q, wd_d;
    logic                aborted_q, aborted_d;
    logic                terr_q, terr_d;
    logic                running;

    assign running = (state_q == StLoadStep) || (state_q == StWaitStep) ||
                     (state_q == StLoadTravel) || (state_q == StWaitTravel);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        travel_d  = travel_q;
        skip_d    = skip_q;
        wd_d      = wd_q;
        aborted_d = 1'b0;
        terr_d    = terr_q;

        unique case (state_q)
            StIdle: begin
                if (start_animation) begin
                    step_d   = '0;
                    travel_d = '0;
                    skip_d   = skip_travel;
                    terr_d   = 1'b0;
                    state_d  = StLoadStep;
                end
            end
            StLoadStep: begin
                wd_d    = '0;
                state_d = StWaitStep;
            end
            StWaitStep: begin
                // A done arriving on the expiry cycle still counts as success.
                if (done_step) begin
                    if (step_q == PROC_LAST) begin
                        state_d = skip_q ? StFinish : StLoadTravel;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = StLoadStep;
                    end
                end else if (wd_q == WD_LAST) begin
                    terr_d   = 1'b1;
                    step_d   = '0;
                    travel_d = '0;
                    state_d  = StIdle;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            StLoadTravel: begin
                wd_d    = '0;
                state_d = StWaitTravel;
            end
            StWaitTravel: begin
                if (done_travel) begin
                    if (travel_q == TRAVEL_LAST) begin
                        state_d = StFinish;
                    end else begin
                        travel_d = travel_q + STEP_W'(1);
                        state_d  = StLoadTravel;
                    end
                end else if (wd_q == WD_LAST) begin
                    terr_d   = 1'b1;
                    step_d   = '0;
                    travel_d = '0;
                    state_d  = StIdle;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            StFinish: begin
                state_d = StHold;
            end
            StHold: begin
                if (return_signal) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // User abort overrides both a done and a watchdog expiry in the same cycle.
        if (running && return_signal) begin
            state_d   = StIdle;
            step_d    = '0;
            travel_d  = '0;
            wd_d      = wd_q;
            terr_d    = terr_q;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            step_q    <= '0;
            travel_q  <= '0;
            skip_q    <= 1'b0;
            wd_q      <= '0;
            aborted_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            travel_q  <= travel_d;
            skip_q    <= skip_d;
            wd_q      <= wd_d;
            aborted_q <= aborted_d;
            terr_q    <= terr_d;
        end
    end

    assign load_screen          = (state_q == StLoadStep) || (state_q == StLoadTravel);
    assign busy                 = (state_q != StIdle);
    assign finished_transaction = (state_q == StFinish);
    assign aborted              = aborted_q;
    assign timeout_err          = terr_q;
    assign step                 = step_q;
    assign travel               = travel_q;

endmodule

// File: tb/tb_animation_sequencer.sv
// Bench for animation_sequencer: directed scenario table, hand-written corner sequences and a
// randomized run checked cycle by cycle against a timeline model built from the step rules.
module tb_animation_sequencer;

    localparam int unsigned PS   = 5;
    localparam int unsigned TS   = 5;
    localparam int unsigned SW   = 3;
    localparam int unsigned TO   = 8;
    localparam int unsigned TW   = 4;
    localparam int          MAXC = 160;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start_animation = 1'b0;
    logic          skip_travel = 1'b0;
    logic          done_step = 1'b0;
    logic          done_travel = 1'b0;
    logic          return_signal = 1'b0;
    logic          load_screen;
    logic [SW-1:0] step;
    logic [SW-1:0] travel;
    logic          busy;
    logic          finished_transaction;
    logic          aborted;
    logic          timeout_err;

    always #5 clock = ~clock;

    animation_sequencer #(
        .PROC_STEPS    (PS),
        .TRAVEL_STEPS  (TS),
        .STEP_W        (SW),
        .TIMEOUT_CYCLES(TO),
        .TO_W          (TW)
    ) dut (
        .clock               (clock),
        .resetn              (resetn),
        .start_animation     (start_animation),
        .skip_travel         (skip_travel),
        .done_step           (done_step),
        .done_travel         (done_travel),
        .return_signal       (return_signal),
        .load_screen         (load_screen),
        .step                (step),
        .travel              (travel),
        .busy                (busy),
        .finished_transaction(finished_transaction),
        .aborted             (aborted),
        .timeout_err         (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {load_screen, busy, finished_transaction, aborted, timeout_err, step, travel};
    endfunction

    // Drive one cycle's inputs just after the edge, return at mid-cycle to sample outputs.
    task automatic tick(input logic st, input logic sk, input logic ds, input logic dt,
                        input logic rt);
        @(posedge clock);
        #1;
        start_animation = st;
        skip_travel     = sk;
        done_step       = ds;
        done_travel     = dt;
        return_signal   = rt;
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        resetn          = 1'b0;
        start_animation = 1'b0;
        skip_travel     = 1'b0;
        done_step       = 1'b0;
        done_travel     = 1'b0;
        return_signal   = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        logic skip;
        int   w_proc;    // wait cycles until done for process steps (>TO means never)
        int   w_trav;
        int   abort_at;  // cycle carrying return_signal, 0 = none
        int   loads;
        int   fin_c;
        int   idle_c;
        logic ab;
        logic terr;
        int   st;
        int   tr;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int idx);
        vec_t v;
        int loads, last_load, fin_c, idle_c, w;
        logic ab, terr;
        int st_seen, tr_seen;
        v = vecs[idx];
        loads = 0; last_load = -100; fin_c = 0; idle_c = 0;
        ab = 1'b0; terr = 1'b0; st_seen = -1; tr_seen = -1;
        tick(1'b1, v.skip, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 200; c++) begin
            w = (loads <= int'(PS)) ? v.w_proc : v.w_trav;
            tick(1'b0, 1'b0,
                 (loads >= 1) && (loads <= int'(PS)) && (c == last_load + w),
                 (loads > int'(PS)) && (c == last_load + w),
                 (c == v.abort_at) || ((fin_c != 0) && (c == fin_c + 1)));
            if (load_screen) begin
                loads++;
                last_load = c;
            end
            if (finished_transaction) fin_c = c;
            if (!busy) begin
                idle_c  = c;
                ab      = aborted;
                terr    = timeout_err;
                st_seen = int'(step);
                tr_seen = int'(travel);
                break;
            end
        end
        check($sformatf("vec%0d loads", idx), loads, v.loads);
        check($sformatf("vec%0d finish_cycle", idx), fin_c, v.fin_c);
        check($sformatf("vec%0d idle_cycle", idx), idle_c, v.idle_c);
        check($sformatf("vec%0d aborted", idx), ab, v.ab);
        check($sformatf("vec%0d timeout_err", idx), terr, v.terr);
        check($sformatf("vec%0d step", idx), st_seen, v.st);
        check($sformatf("vec%0d travel", idx), tr_seen, v.tr);
    endtask

    // Timeline model: expected outputs and stimulus per cycle after an accepted start.
    logic e_load[MAXC], e_busy[MAXC], e_fin[MAXC], e_ab[MAXC], e_terr[MAXC];
    int   e_st[MAXC], e_tr[MAXC], phase[MAXC];
    logic i_st[MAXC], i_ds[MAXC], i_dt[MAXC], i_rt[MAXC];

    task automatic build(input logic skip, input bit do_abort, output int endc);
        int n, c, w, s, t, ph, last_run, a, fs, ft, span;
        bit to;
        n = int'(PS) + (skip ? 0 : int'(TS));
        c = 1; to = 1'b0; last_run = 0;
        for (int i = 0; i < MAXC; i++) begin
            e_load[i] = 0; e_busy[i] = 0; e_fin[i] = 0; e_ab[i] = 0; e_terr[i] = 0;
            e_st[i] = 0; e_tr[i] = 0; phase[i] = 0;
            i_st[i] = 0; i_ds[i] = 0; i_dt[i] = 0; i_rt[i] = 0;
        end
        for (int k = 0; k < n; k++) begin
            w  = ($urandom_range(0, 23) == 0) ? int'(TO) + 1 : int'($urandom_range(1, TO));
            s  = (k < int'(PS)) ? k : int'(PS) - 1;
            t  = (k < int'(PS)) ? 0 : k - int'(PS);
            ph = (k < int'(PS)) ? 1 : 2;
            span = (w <= int'(TO)) ? w : int'(TO);
            for (int j = 0; j <= span; j++) begin
                e_busy[c+j] = 1; e_load[c+j] = (j == 0);
                e_st[c+j] = s; e_tr[c+j] = t; phase[c+j] = ph;
            end
            if (w <= int'(TO)) begin
                if (ph == 1) i_ds[c+w] = 1; else i_dt[c+w] = 1;
                c = c + w + 1;
            end else begin
                last_run = c + int'(TO);
                c = c + int'(TO) + 1;
                to = 1'b1;
                break;
            end
        end
        if (!to) begin
            last_run = c - 1;
            fs = int'(PS) - 1;
            ft = skip ? 0 : int'(TS) - 1;
            span = int'($urandom_range(1, 4));
            for (int j = 0; j <= span; j++) begin
                e_busy[c+j] = 1; e_fin[c+j] = (j == 0);
                e_st[c+j] = fs; e_tr[c+j] = ft; phase[c+j] = 3;
            end
            i_rt[c+span] = 1;
            endc = c + span + 1;
            e_st[endc] = fs; e_tr[endc] = ft;
        end else begin
            endc = c;
            e_terr[endc] = 1;
        end
        if (do_abort) begin
            a = int'($urandom_range(1, last_run));
            for (int i = a + 1; i < MAXC; i++) begin
                e_load[i] = 0; e_busy[i] = 0; e_fin[i] = 0; e_ab[i] = 0; e_terr[i] = 0;
                e_st[i] = 0; e_tr[i] = 0; phase[i] = 0;
                i_ds[i] = 0; i_dt[i] = 0; i_rt[i] = 0;
            end
            i_rt[a] = 1;
            endc = a + 1;
            e_ab[endc] = 1;
        end
        // Stray inputs that must all be ignored.
        for (int i = 1; i <= endc; i++) begin
            if (e_busy[i] && $urandom_range(0, 7) == 0) i_st[i] = 1;
            if (phase[i] != 2 && $urandom_range(0, 7) == 0) i_dt[i] = 1;
            if (phase[i] != 1 && $urandom_range(0, 7) == 0) i_ds[i] = 1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int endc;
        logic skip;
        logic [10:0] exp_o;

        vecs[0] = '{1'b0, 1, 1, 0, 10, 21, 23, 1'b0, 1'b0, 4, 4};
        vecs[1] = '{1'b1, 1, 1, 0, 5, 11, 13, 1'b0, 1'b0, 4, 0};
        vecs[2] = '{1'b0, 3, 3, 0, 10, 41, 43, 1'b0, 1'b0, 4, 4};
        vecs[3] = '{1'b1, 8, 1, 0, 5, 46, 48, 1'b0, 1'b0, 4, 0};
        vecs[4] = '{1'b0, 9, 1, 0, 1, 0, 10, 1'b0, 1'b1, 0, 0};
        vecs[5] = '{1'b0, 1, 1, 6, 3, 0, 7, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{1'b0, 1, 1, 13, 7, 0, 14, 1'b1, 1'b0, 0, 0};
        vecs[7] = '{1'b0, 1, 9, 0, 6, 0, 20, 1'b0, 1'b1, 0, 0};
        vecs[8] = '{1'b0, 9, 1, 9, 1, 0, 10, 1'b1, 1'b0, 0, 0};

        // Reset state
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("reset outputs", outs(), 11'h0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_reset();
            run_vec(i);
        end

        // Watchdog flag is sticky in IDLE and cleared by the next accepted start.
        do_reset();
        run_vec(7);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("terr sticky", timeout_err, 1'b1);
        check("terr idle busy", busy, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("terr cleared", timeout_err, 1'b0);
        check("restart load", {load_screen, busy}, 2'b11);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart abort", {aborted, busy}, 2'b10);

        // Stray inputs, then reset mid-travel.
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stray step1 load", {load_screen, step}, {1'b1, 3'd1});
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stray ignored", {load_screen, busy, step, travel}, {1'b0, 1'b1, 3'd1, 3'd0});
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stray step2 load", {load_screen, step}, {1'b1, 3'd2});
        for (int k = 3; k <= 4; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("travel1 load", {load_screen, step, travel}, {1'b1, 3'd4, 3'd1});
        @(posedge clock);
        #1;
        resetn = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("mid-travel reset", outs(), 11'h0);
        resetn = 1'b1;

        // Randomized transactions against the timeline model.
        do_reset();
        for (int n = 0; n < 30; n++) begin
            skip = 1'($urandom_range(0, 1));
            build(skip, ($urandom_range(0, 3) == 0), endc);
            tick(1'b1, skip, 1'b0, 1'b0, 1'b0);
            for (int c = 1; c <= endc; c++) begin
                tick(i_st[c], 1'($urandom_range(0, 1)), i_ds[c], i_dt[c], i_rt[c]);
                exp_o = {e_load[c], e_busy[c], e_fin[c], e_ab[c], e_terr[c],
                         SW'(e_st[c]), SW'(e_tr[c])};
                check($sformatf("rand t%0d c%0d", n, c), outs(), exp_o);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
